t9990_layer_mux: RTL and testbench

//  Parametrised successor to the fixed 4-layer SP/PA/PB/BP priority mux of the tiny9990 video path.

---
 rtl/t9990_layer_pkg.sv | 24 ++
 rtl/t9990_layer_delay.sv | 36 +++
 rtl/t9990_layer_mux.sv | 178 +++++++++++++++++
 tb/tb_t9990_layer_mux.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t9990_layer_pkg.sv
// Shared types and helpers for the tiny9990 layer mux: priority width,
// transparency test and the reset/identity layer order.
package t9990_layer_pkg;

  localparam int PRI_W      = 2;
  localparam int MAX_LAYERS = 8;
  localparam int MAX_IDX_W  = 3;

  // Sized for the largest supported mux; narrower instances use the low slices.
  typedef logic [MAX_LAYERS-1:0][MAX_IDX_W-1:0] order_arr_t;

  function automatic logic is_opaque(input logic [3:0] pa);
    return |pa;
  endfunction

  function automatic order_arr_t identity_order();
    order_arr_t o;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      o[i] = MAX_IDX_W'(i);
    end
    return o;
  endfunction

endpackage

// File: rtl/t9990_layer_delay.sv
// Dot-clock-enabled shift line of DEPTH registers; DEPTH=0 is a plain wire.
module t9990_layer_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst_n ^ i_en;
      assign o_q      = i_d;
    end else begin : g_line
      logic [DEPTH-1:0][WIDTH-1:0] r_line;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_line <= '0;
        end else if (i_en) begin
          r_line[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) begin
            r_line[i] <= r_line[i-1];
          end
        end
      end

      assign o_q = r_line[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/t9990_layer_mux.sv
// Programmable-order priority mux of NUM_LAYERS palette layers with matched sync delay.
// Optional sticky sprite collision flags: define T9990_LAYER_MUX_COLLISION_EN.
module t9990_layer_mux
  import t9990_layer_pkg::*;
#(
  parameter int NUM_LAYERS  = 4,
  parameter int PA_W        = 6,
  parameter int PIPE_STAGES = 2,
  localparam int IDX_W      = (NUM_LAYERS < 2) ? 1 : $clog2(NUM_LAYERS)
) (
  input  logic                                 CLK,
  input  logic                                 RESET_n,
  input  logic                                 DCLK_EN,
  input  logic                                 VDE,
  input  logic                                 HDE,
  input  logic                                 HS_IN,
  input  logic                                 VS_IN,
  input  logic [NUM_LAYERS-1:0]                LAYER_DISABLE,
  input  logic [NUM_LAYERS-1:0][PRI_W-1:0]     LAYER_PRI,
  input  logic [NUM_LAYERS-1:0][PA_W-1:0]      LAYER_PA,
  input  logic [PA_W-1:0]                      BDC,
  input  logic                                 ORDER_WR,
  input  logic [NUM_LAYERS-1:0][IDX_W-1:0]     ORDER_IN,
  input  logic                                 COLL_CLR,
  output logic [PA_W-1:0]                      OUT_PA,
  output logic                                 OUT_PRI,
  output logic [IDX_W-1:0]                     OUT_LAYER,
  output logic                                 HS_OUT,
  output logic                                 VS_OUT,
  output logic [NUM_LAYERS-1:0]                COLL
);

  localparam order_arr_t IDENT = identity_order();
  localparam int         DW    = PA_W + 1 + IDX_W + 2;

  logic                                r_vs_prev;
  logic [NUM_LAYERS-1:0][IDX_W-1:0]    r_order_act;
  logic [NUM_LAYERS-1:0][IDX_W-1:0]    r_order_pend;
  logic                                w_frame_start;
  logic                                w_active;
  logic [NUM_LAYERS-1:0]               w_present;
  logic [NUM_LAYERS-1:0]               w_cand;
  logic                                w_found;
  logic [PRI_W-1:0]                    w_best_pri;
  logic [IDX_W-1:0]                    w_best_idx;
  logic [PA_W-1:0]                     w_best_pa;

  logic [PA_W-1:0]                     r_pa_p0;
  logic                                r_pri_p0;
  logic [IDX_W-1:0]                    r_layer_p0;
  logic                                r_hs_p0;
  logic                                r_vs_p0;
  logic [DW-1:0]                       w_stage_d;
  logic [DW-1:0]                       w_stage_q;

  // A write landing on the frame-start tick bypasses pending so it takes effect this frame.
  assign w_frame_start = DCLK_EN && VS_IN && !r_vs_prev;
  assign w_active      = VDE && HDE;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_vs_prev <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_order_act[i]  <= IDENT[i][IDX_W-1:0];
        r_order_pend[i] <= IDENT[i][IDX_W-1:0];
      end
    end else begin
      if (DCLK_EN) begin
        r_vs_prev <= VS_IN;
      end
      if (ORDER_WR) begin
        r_order_pend <= ORDER_IN;
      end
      if (w_frame_start) begin
        r_order_act <= ORDER_WR ? ORDER_IN : r_order_pend;
      end
    end
  end

  // Layers named nowhere in the active order (incl. out-of-range indices) never compete.
  always_comb begin
    w_present = '0;
    for (int p = 0; p < NUM_LAYERS; p++) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (r_order_act[p] == IDX_W'(l)) begin
          w_present[l] = 1'b1;
        end
      end
    end
    for (int l = 0; l < NUM_LAYERS; l++) begin
      w_cand[l] = w_present[l] && !LAYER_DISABLE[l] && is_opaque(LAYER_PA[l][3:0]);
    end
  end

  // Scan front to back; only a strictly higher priority displaces, so ties and
  // duplicate entries resolve to the frontmost position.
  always_comb begin
    w_found    = 1'b0;
    w_best_pri = '0;
    w_best_idx = '0;
    w_best_pa  = '0;
    for (int p = 0; p < NUM_LAYERS; p++) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if ((r_order_act[p] == IDX_W'(l)) && w_cand[l] &&
            (!w_found || (LAYER_PRI[l] > w_best_pri))) begin
          w_found    = 1'b1;
          w_best_pri = LAYER_PRI[l];
          w_best_idx = IDX_W'(l);
          w_best_pa  = LAYER_PA[l];
        end
      end
    end
  end

  // ---- compute stage -> p0 ----
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_pa_p0    <= '0;
      r_pri_p0   <= 1'b0;
      r_layer_p0 <= '0;
      r_hs_p0    <= 1'b0;
      r_vs_p0    <= 1'b0;
    end else if (DCLK_EN) begin
      r_pa_p0    <= (w_active && w_found) ? w_best_pa : BDC;
      r_pri_p0   <= w_active && w_found;
      r_layer_p0 <= (w_active && w_found) ? w_best_idx : '0;
      r_hs_p0    <= HS_IN;
      r_vs_p0    <= VS_IN;
    end
  end

  // ---- p0 -> output: PIPE_STAGES-1 matched delay stages ----
  assign w_stage_d = {r_pa_p0, r_pri_p0, r_layer_p0, r_hs_p0, r_vs_p0};

  t9990_layer_delay #(
    .WIDTH (DW),
    .DEPTH (PIPE_STAGES - 1)
  ) u_delay (
    .i_clk   (CLK),
    .i_rst_n (RESET_n),
    .i_en    (DCLK_EN),
    .i_d     (w_stage_d),
    .o_q     (w_stage_q)
  );

  assign {OUT_PA, OUT_PRI, OUT_LAYER, HS_OUT, VS_OUT} = w_stage_q;

`ifdef T9990_LAYER_MUX_COLLISION_EN
  logic [NUM_LAYERS-1:0] r_coll;
  logic [NUM_LAYERS-1:0] w_hit;

  // Bit 0 of w_hit stays clear; it is folded in below as "any sprite hit".
  always_comb begin
    w_hit = '0;
    if (DCLK_EN && w_active && w_cand[0]) begin
      for (int k = 1; k < NUM_LAYERS; k++) begin
        w_hit[k] = w_cand[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_coll <= '0;
    end else begin
      r_coll <= (COLL_CLR ? '0 : r_coll) | w_hit |
                {{(NUM_LAYERS-1){1'b0}}, |w_hit};
    end
  end

  assign COLL = r_coll;
`else
  logic w_unused_coll_clr;
  assign w_unused_coll_clr = COLL_CLR;
  assign COLL              = '0;
`endif

endmodule

// File: tb/tb_t9990_layer_mux.sv
// Scoreboard bench for t9990_layer_mux: two instances (2-stage and 4-stage pipe) share stimulus.
module tb_t9990_layer_mux;

  typedef struct packed {
    logic [5:0] pa;
    logic       pri;
    logic [1:0] lay;
    logic       hs;
    logic       vs;
  } exp_t;

`ifdef T9990_LAYER_MUX_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RESET_n;
  logic            DCLK_EN;
  logic            VDE, HDE, HS_IN, VS_IN;
  logic [3:0]      LAYER_DISABLE;
  logic [3:0][1:0] LAYER_PRI;
  logic [3:0][5:0] LAYER_PA;
  logic [5:0]      BDC;
  logic            ORDER_WR;
  logic [3:0][1:0] ORDER_IN;
  logic            COLL_CLR;

  logic [5:0] pa2, pa4;
  logic       pri2, pri4, hs2, hs4, vs2, vs4;
  logic [1:0] lay2, lay4;
  logic [3:0] coll2, coll4;

  exp_t q2[$];
  exp_t q4[$];
  exp_t last2, last4;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  t9990_layer_mux #(.NUM_LAYERS(4), .PA_W(6), .PIPE_STAGES(2)) u_dut (
    .CLK(CLK), .RESET_n(RESET_n), .DCLK_EN(DCLK_EN), .VDE(VDE), .HDE(HDE),
    .HS_IN(HS_IN), .VS_IN(VS_IN), .LAYER_DISABLE(LAYER_DISABLE), .LAYER_PRI(LAYER_PRI),
    .LAYER_PA(LAYER_PA), .BDC(BDC), .ORDER_WR(ORDER_WR), .ORDER_IN(ORDER_IN),
    .COLL_CLR(COLL_CLR), .OUT_PA(pa2), .OUT_PRI(pri2), .OUT_LAYER(lay2),
    .HS_OUT(hs2), .VS_OUT(vs2), .COLL(coll2));

  t9990_layer_mux #(.NUM_LAYERS(4), .PA_W(6), .PIPE_STAGES(4)) u_dut4 (
    .CLK(CLK), .RESET_n(RESET_n), .DCLK_EN(DCLK_EN), .VDE(VDE), .HDE(HDE),
    .HS_IN(HS_IN), .VS_IN(VS_IN), .LAYER_DISABLE(LAYER_DISABLE), .LAYER_PRI(LAYER_PRI),
    .LAYER_PA(LAYER_PA), .BDC(BDC), .ORDER_WR(ORDER_WR), .ORDER_IN(ORDER_IN),
    .COLL_CLR(COLL_CLR), .OUT_PA(pa4), .OUT_PRI(pri4), .OUT_LAYER(lay4),
    .HS_OUT(hs4), .VS_OUT(vs4), .COLL(coll4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: on each dot tick compare the dot now leaving each pipe; while stalled
  // the outputs must still show the last dot that left.
  initial begin
    logic en_s;
    last2 = '0;
    last4 = '0;
    forever begin
      @(posedge CLK);
      en_s = DCLK_EN;
      #2;
      if (RESET_n) begin
        if (en_s) begin
          if (q2.size() >= 2) begin
            last2 = q2.pop_front();
            chk("pipe2", {pa2, pri2, lay2, hs2, vs2}, last2);
          end
          if (q4.size() >= 4) begin
            last4 = q4.pop_front();
            chk("pipe4", {pa4, pri4, lay4, hs4, vs4}, last4);
          end
        end else begin
          chk("hold2", {pa2, pri2, lay2, hs2, vs2}, last2);
          chk("hold4", {pa4, pri4, lay4, hs4, vs4}, last4);
        end
      end
    end
  end

  task automatic tick(input logic [5:0] pa, input logic pri, input logic [1:0] lay);
    exp_t e;
    e.pa  = pa;
    e.pri = pri;
    e.lay = lay;
    e.hs  = HS_IN;
    e.vs  = VS_IN;
    q2.push_back(e);
    q4.push_back(e);
    DCLK_EN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    DCLK_EN = 1'b0;
  endtask

  task automatic set_order(input logic [1:0] p0, input logic [1:0] p1,
                           input logic [1:0] p2, input logic [1:0] p3);
    ORDER_IN[0] = p0;
    ORDER_IN[1] = p1;
    ORDER_IN[2] = p2;
    ORDER_IN[3] = p3;
  endtask

  task automatic strobe_wr;
    ORDER_WR = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ORDER_WR = 1'b0;
  endtask

  task automatic strobe_clr;
    COLL_CLR = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    COLL_CLR = 1'b0;
  endtask

  task automatic set_pa(input logic [5:0] a0, input logic [5:0] a1,
                        input logic [5:0] a2, input logic [5:0] a3);
    LAYER_PA[0] = a0;
    LAYER_PA[1] = a1;
    LAYER_PA[2] = a2;
    LAYER_PA[3] = a3;
  endtask

  initial begin
    RESET_n = 1'b0; DCLK_EN = 1'b0; VDE = 1'b1; HDE = 1'b1; HS_IN = 1'b0; VS_IN = 1'b0;
    LAYER_DISABLE = '0; LAYER_PRI = '0; BDC = 6'h2A; ORDER_WR = 1'b0; COLL_CLR = 1'b0;
    set_pa(6'h01, 6'h12, 6'h23, 6'h34);
    set_order(2'd0, 2'd1, 2'd2, 2'd3);
    repeat (2) @(negedge CLK);
    chk("reset_out2", {pa2, pri2, lay2, hs2, vs2}, 32'h0);
    chk("reset_out4", {pa4, pri4, lay4, hs4, vs4}, 32'h0);
    chk("reset_coll", {coll2, coll4}, 32'h0);
    RESET_n = 1'b1;
    @(negedge CLK);

    // Identity order, equal priority: front layer wins
    tick(6'h01, 1'b1, 2'd0);
    HS_IN = 1'b1;
    tick(6'h01, 1'b1, 2'd0);
    HS_IN = 1'b0;
    tick(6'h01, 1'b1, 2'd0);

    // Priority and transparency
    LAYER_PRI[2] = 2'd3;
    tick(6'h23, 1'b1, 2'd2);
    LAYER_PA[2] = 6'h20;
    tick(6'h01, 1'b1, 2'd0);
    LAYER_PA[2] = 6'h23;
    LAYER_PRI[2] = 2'd0;
    LAYER_DISABLE = 4'b0001;
    tick(6'h12, 1'b1, 2'd1);
    LAYER_DISABLE = 4'b0000;

    // Backdrop: all transparent, then outside active area
    set_pa(6'h00, 6'h10, 6'h20, 6'h30);
    tick(6'h2A, 1'b0, 2'd0);
    set_pa(6'h01, 6'h12, 6'h23, 6'h34);
    HDE = 1'b0;
    tick(6'h2A, 1'b0, 2'd0);
    HDE = 1'b1; VDE = 1'b0;
    tick(6'h2A, 1'b0, 2'd0);
    VDE = 1'b1;

    // Mid-frame order write waits for VS_IN rise
    set_order(2'd3, 2'd2, 2'd1, 2'd0);
    strobe_wr();
    tick(6'h01, 1'b1, 2'd0);
    tick(6'h01, 1'b1, 2'd0);
    VS_IN = 1'b1;
    tick(6'h01, 1'b1, 2'd0);
    tick(6'h34, 1'b1, 2'd3);
    VS_IN = 1'b0;
    tick(6'h34, 1'b1, 2'd3);
    LAYER_PRI[1] = 2'd2;
    tick(6'h12, 1'b1, 2'd1);
    LAYER_PRI[1] = 2'd0;

    // Write in the same CLK as the VS_IN edge applies at once
    set_order(2'd0, 2'd1, 2'd2, 2'd3);
    ORDER_WR = 1'b1; VS_IN = 1'b1;
    tick(6'h34, 1'b1, 2'd3);
    ORDER_WR = 1'b0;
    tick(6'h01, 1'b1, 2'd0);

    // Duplicate entry and absent layer 0
    VS_IN = 1'b0;
    tick(6'h01, 1'b1, 2'd0);
    set_order(2'd2, 2'd2, 2'd1, 2'd3);
    ORDER_WR = 1'b1; VS_IN = 1'b1;
    tick(6'h01, 1'b1, 2'd0);
    ORDER_WR = 1'b0;
    tick(6'h23, 1'b1, 2'd2);
    LAYER_PA[2] = 6'h20;
    tick(6'h12, 1'b1, 2'd1);
    LAYER_PA[2] = 6'h23;
    VS_IN = 1'b0;
    tick(6'h23, 1'b1, 2'd2);
    set_order(2'd0, 2'd1, 2'd2, 2'd3);
    ORDER_WR = 1'b1; VS_IN = 1'b1;
    tick(6'h23, 1'b1, 2'd2);
    ORDER_WR = 1'b0; VS_IN = 1'b0;
    tick(6'h01, 1'b1, 2'd0);

    // Stall for 5 CLK mid-stream; no dot may be lost
    LAYER_PRI[3] = 2'd1; HS_IN = 1'b1;
    tick(6'h34, 1'b1, 2'd3);
    repeat (5) @(negedge CLK);
    LAYER_PRI[3] = 2'd0; LAYER_PRI[1] = 2'd1; HS_IN = 1'b0;
    tick(6'h12, 1'b1, 2'd1);
    LAYER_PRI[1] = 2'd0;
    repeat (4) tick(6'h01, 1'b1, 2'd0);

    // Collision between sprite layer 0 and layer 2
    set_pa(6'h01, 6'h10, 6'h23, 6'h30);
    tick(6'h01, 1'b1, 2'd0);
    chk("coll_set2", coll2, COLL_EN ? 32'h5 : 32'h0);
    chk("coll_set4", coll4, COLL_EN ? 32'h5 : 32'h0);
    set_pa(6'h00, 6'h10, 6'h23, 6'h30);
    tick(6'h23, 1'b1, 2'd2);
    chk("coll_sticky", coll2, COLL_EN ? 32'h5 : 32'h0);
    strobe_clr();
    chk("coll_clr", coll2, 32'h0);
    set_pa(6'h01, 6'h10, 6'h23, 6'h30);
    COLL_CLR = 1'b1;
    tick(6'h01, 1'b1, 2'd0);
    COLL_CLR = 1'b0;
    chk("coll_clr_hit", coll2, COLL_EN ? 32'h5 : 32'h0);
    set_pa(6'h01, 6'h12, 6'h23, 6'h34);

    // Reset mid-frame: reversed order active, then async reset
    VS_IN = 1'b0;
    tick(6'h01, 1'b1, 2'd0);
    set_order(2'd3, 2'd2, 2'd1, 2'd0);
    ORDER_WR = 1'b1; VS_IN = 1'b1;
    tick(6'h01, 1'b1, 2'd0);
    ORDER_WR = 1'b0;
    tick(6'h34, 1'b1, 2'd3);
    RESET_n = 1'b0;
    q2.delete(); q4.delete();
    last2 = '0; last4 = '0;
    #1;
    chk("midrst_out2", {pa2, pri2, lay2, hs2, vs2}, 32'h0);
    chk("midrst_out4", {pa4, pri4, lay4, hs4, vs4}, 32'h0);
    chk("midrst_coll", {coll2, coll4}, 32'h0);
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1; VS_IN = 1'b0;
    @(negedge CLK);
    repeat (5) tick(6'h01, 1'b1, 2'd0);

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
